iter_shift_engine: RTL and testbench
====================================

Name: iter_shift_engine

Overview:
Sequential variable-amount shift/rotate engine. It accepts a word plus a shift amount over a valid/ready handshake and applies the amount iteratively: coarse steps of STEP bits, then single-bit steps. Each step goes through a fixed-amount combinational shift stage. The block sits in front of downstream datapath stages that need arbitrary shifts without a full barrel shifter.

Parameters:
DATA_WIDTH, 16, data word width; must be a power of 2, >= 4
STEP, 4, coarse step size in bits; 1 < STEP < DATA_WIDTH
AMT_WIDTH, $clog2(DATA_WIDTH), shift-amount width (amount always < DATA_WIDTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  engine can accept (high only in IDLE)
in_data  input  DATA_WIDTH  operand
in_amt  input  AMT_WIDTH  shift amount, 0..DATA_WIDTH-1
in_dir  input  1  1 = left, 0 = right
in_rot  input  1  1 = rotate, 0 = logical (zero fill)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  DATA_WIDTH  shifted result
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, out_data=0, busy=0, in_ready=1 after release; internal remainder=0.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid at edge T, capture data, amt, dir and rot. Next state is DONE if amt==0, else SHIFT.
- SHIFT: one iteration per cycle.
  - If rem >= STEP: shift/rotate by STEP and set rem -= STEP.
  - Else: shift/rotate by 1 and set rem -= 1.
  - The iteration that makes rem 0 moves the state to DONE.
- Iteration count N = floor(amt/STEP) + (amt mod STEP). out_valid rises at T+1+N.
- DONE: out_valid=1 and out_data is held stable until out_ready is sampled high. Then go to IDLE; out_valid falls the next cycle.
- A result and a new request are never accepted in the same cycle: in_ready=0 in DONE. Throughput is one op per N+2 cycles.
- Logical shifts zero-fill the vacated bits. Rotate wraps bits. Direction is fixed per operation.
- in_* are ignored outside IDLE. Changing them mid-operation has no effect.
- out_ready while not DONE is ignored.
- rst asserted mid-operation: immediate abort, return to reset values, and the result is discarded.
- in_amt values >= DATA_WIDTH cannot be expressed (AMT_WIDTH bounds them).

Optional Feature:
Macro ITER_SHIFT_STICKY_EN.
- Defined: adds output port out_sticky (1 bit).
  - Logical mode: out_sticky is the OR of every 1-bit discarded across all iterations. It accumulates from 0 at capture and is valid with out_valid.
  - Rotate mode: out_sticky=0. Reset value 0.
- Undefined: no port and no accumulator logic.

Decomposition:
- Package iter_shift_pkg:
  - state enum type (IDLE/SHIFT/DONE)
  - direction constants DIR_LEFT=1 / DIR_RIGHT=0
  - mode constants MODE_ROT=1 / MODE_LOG=0
- Sub-module step_shift_core: combinational fixed-amount shifter parameterised by DATA_WIDTH and amount, with runtime dir/rot inputs. Instantiate twice, once with amount STEP and once with amount 1; the engine muxes between them.

Test Plan (DATA_WIDTH=16, STEP=4):
- in_data=0x1234, amt=4, left rotate -> N=1; out_data=0x2341 at T+2.
- in_data=0x1234, amt=6, left logical -> N=3; out_data=0x8D00 at T+4.
- in_data=0x1234, amt=15, right rotate -> N=6; out_data=0x2468 at T+7.
- amt=0, in_data=0xBEEF -> out_valid at T+1, out_data=0xBEEF.
  - Hold out_ready=0 for 5 cycles: out_valid and out_data are stable, in_ready=0 throughout.
  - Then out_ready=1: IDLE next cycle.
- Assert rst during SHIFT of an amt=15 operation: all outputs return to reset values asynchronously. A new request after release completes correctly with no residue.
- With ITER_SHIFT_STICKY_EN, right logical:
  - 0x0013 by 4 -> 0x0001, sticky=1.
  - 0x0010 by 4 -> 0x0001, sticky=0.
  - Any rotate -> sticky=0.

Source files
------------

// File: rtl/iter_shift_engine_pkg.sv
// Package for the iterative shift/rotate engine.
// Holds the FSM state type plus the direction and mode encodings shared by
// the engine, its fixed-amount shift core and the bench.
// No ports (package).
package iter_shift_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic MODE_ROT  = 1'b1;
   localparam logic MODE_LOG  = 1'b0;

endpackage : iter_shift_pkg

// File: rtl/iter_shift_engine_if.sv
// Request/result bus of the iterative shift/rotate engine.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; the sender holds its payload stable while valid is high and
// ready is low. The request side uses in_valid/in_ready, the result side
// uses out_valid/out_ready.
// Signals:
//   in_valid, in_data, in_amt, in_dir, in_rot : request (master -> engine)
//   in_ready                                  : engine can accept
//   out_valid, out_data                       : result (engine -> master)
//   out_ready                                 : consumer accepts result
// Modports: master (requester/consumer side), slave (engine side).
interface iter_shift_if #(
   parameter int DATA_WIDTH = 16,
   parameter int AMT_WIDTH  = $clog2(DATA_WIDTH)
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic [AMT_WIDTH-1:0]  in_amt;
   logic                  in_dir;
   logic                  in_rot;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, in_amt, in_dir, in_rot, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_dir, in_rot, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface : iter_shift_if

// File: rtl/iter_shift_engine_step_shift_core.sv
// Combinational fixed-amount shifter.
// Shifts or rotates data by the compile-time amount SHIFT; direction and
// mode are chosen at run time.
// Ports:
//   data   : operand
//   dir    : 1 = left, 0 = right
//   rot    : 1 = rotate, 0 = logical (zero fill)
//   result : shifted/rotated operand
module step_shift_core
   import iter_shift_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int SHIFT      = 1
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  dir,
   input  logic                  rot,
   output logic [DATA_WIDTH-1:0] result
);

   logic [DATA_WIDTH-1:0] shl;
   logic [DATA_WIDTH-1:0] shr;
   logic [DATA_WIDTH-1:0] wrap_l;
   logic [DATA_WIDTH-1:0] wrap_r;

   assign shl    = data << SHIFT;
   assign shr    = data >> SHIFT;
   // Bits that fall off one end re-enter at the other when rotating.
   assign wrap_l = data >> (DATA_WIDTH - SHIFT);
   assign wrap_r = data << (DATA_WIDTH - SHIFT);

   always_comb begin
      result = '0;
      if (dir == DIR_LEFT) begin
         result = (rot == MODE_ROT) ? (shl | wrap_l) : shl;
      end else begin
         result = (rot == MODE_ROT) ? (shr | wrap_r) : shr;
      end
   end

endmodule : step_shift_core

// File: rtl/iter_shift_engine.sv
// Iterative variable-amount shift/rotate engine.
// A captured word is shifted by STEP bits per cycle while the remaining
// amount is at least STEP, then by one bit per cycle until it reaches zero.
// The result is then held on the output until the consumer takes it.
// Optional macro ITER_SHIFT_STICKY_EN adds out_sticky: OR of every 1-bit
// discarded by a logical shift (always 0 for rotates).
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   bus       : request/result bus (slave modport of iter_shift_if)
//   busy      : high in SHIFT or DONE
//   dbg_state : current FSM state, for observation
//   out_sticky: (ITER_SHIFT_STICKY_EN only) discarded-ones flag
module iter_shift_engine
   import iter_shift_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int STEP       = 4,
   parameter int AMT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic         clk,
   input  logic         rst,
   iter_shift_if.slave  bus,
   output logic         busy,
   output state_t       dbg_state
`ifdef ITER_SHIFT_STICKY_EN
   ,
   output logic         out_sticky
`endif
);

   localparam logic [AMT_WIDTH-1:0] STEP_AMT = AMT_WIDTH'(STEP);
   localparam logic [AMT_WIDTH-1:0] ONE_AMT  = AMT_WIDTH'(1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [AMT_WIDTH-1:0]  rem_q, rem_d;
   logic                  dir_q, dir_d;
   logic                  rot_q, rot_d;

   logic [DATA_WIDTH-1:0] coarse_res;
   logic [DATA_WIDTH-1:0] fine_res;
   logic                  use_coarse;

   assign use_coarse = (rem_q >= STEP_AMT);

   step_shift_core #(.DATA_WIDTH(DATA_WIDTH), .SHIFT(STEP)) u_coarse (
      .data   (data_q),
      .dir    (dir_q),
      .rot    (rot_q),
      .result (coarse_res)
   );

   step_shift_core #(.DATA_WIDTH(DATA_WIDTH), .SHIFT(1)) u_fine (
      .data   (data_q),
      .dir    (dir_q),
      .rot    (rot_q),
      .result (fine_res)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
      rot_d   = rot_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               data_d  = bus.in_data;
               rem_d   = bus.in_amt;
               dir_d   = bus.in_dir;
               rot_d   = bus.in_rot;
               state_d = (bus.in_amt == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (use_coarse) begin
               data_d = coarse_res;
               rem_d  = rem_q - STEP_AMT;
            end else begin
               data_d = fine_res;
               rem_d  = rem_q - ONE_AMT;
            end
            if (rem_d == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         rot_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         rot_q   <= rot_d;
      end
   end

`ifdef ITER_SHIFT_STICKY_EN
   logic sticky_q, sticky_d;
   logic dropped;

   // Bits leaving the word in this iteration: low end for right shifts,
   // high end for left shifts.
   always_comb begin
      dropped = 1'b0;
      if (use_coarse) begin
         dropped = (dir_q == DIR_LEFT) ? |data_q[DATA_WIDTH-1 -: STEP]
                                       : |data_q[STEP-1:0];
      end else begin
         dropped = (dir_q == DIR_LEFT) ? data_q[DATA_WIDTH-1] : data_q[0];
      end
   end

   always_comb begin
      sticky_d = sticky_q;
      if (state_q == ST_IDLE && bus.in_valid) begin
         sticky_d = 1'b0;
      end else if (state_q == ST_SHIFT && rot_q == MODE_LOG) begin
         sticky_d = sticky_q | dropped;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign out_sticky = (state_q == ST_DONE) ? sticky_q : 1'b0;
`endif

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.out_data  = (state_q == ST_DONE) ? data_q : '0;
   assign busy          = (state_q != ST_IDLE);
   assign dbg_state     = state_q;

endmodule : iter_shift_engine

// File: tb/tb_iter_shift_engine.sv
// Directed bench for iter_shift_engine (DATA_WIDTH=16, STEP=4).
module tb_iter_shift_engine;
   import iter_shift_pkg::*;

   localparam int DW = 16;
   localparam int AW = 4;

   logic   clk;
   logic   rst;
   logic   busy;
   state_t dbg_state;
`ifdef ITER_SHIFT_STICKY_EN
   logic   out_sticky;
`endif

   int checks;
   int errors;

   iter_shift_if #(.DATA_WIDTH(DW), .AMT_WIDTH(AW)) bus ();

   iter_shift_engine #(.DATA_WIDTH(DW), .STEP(4), .AMT_WIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .dbg_state (dbg_state)
`ifdef ITER_SHIFT_STICKY_EN
      ,
      .out_sticky(out_sticky)
`endif
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request, measure latency, optionally stall, then consume.
   task automatic run_op(input string tag, input logic [DW-1:0] d, input logic [AW-1:0] a,
                         input logic dir, input logic rot, input logic [DW-1:0] exp_d,
                         input int exp_lat, input logic exp_sticky, input int hold);
      int lat;
      logic [DW-1:0] first_d;
      @(negedge clk);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_amt   = a;
      bus.in_dir   = dir;
      bus.in_rot   = rot;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      // Scramble inputs: must not affect the running operation.
      bus.in_data  = DW'($urandom_range(0, 65535));
      bus.in_amt   = AW'($urandom_range(0, 15));
      bus.in_dir   = ~dir;
      bus.in_rot   = ~rot;
      lat = 0;
      @(negedge clk);
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_data"}, 32'(bus.out_data), 32'(exp_d));
`ifdef ITER_SHIFT_STICKY_EN
      chk({tag, "_sticky"}, 32'(out_sticky), 32'(exp_sticky));
`else
      if (exp_sticky === 1'bx) $display("unused sticky expectation");
`endif
      first_d = bus.out_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
         chk({tag, "_hold_data"}, 32'(bus.out_data), 32'(first_d));
         chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      chk({tag, "_busy_done"}, 32'(busy), 32'd1);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
      chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_amt    = '0;
      bus.in_dir    = 1'b0;
      bus.in_rot    = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // out_ready while idle must be ignored
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("idle_out_ready_ignored", 32'(dbg_state), 32'(ST_IDLE));

      run_op("rotl4",   16'h1234, 4'd4,  DIR_LEFT,  MODE_ROT, 16'h2341, 1, 1'b0, 0);
      run_op("logl6",   16'h1234, 4'd6,  DIR_LEFT,  MODE_LOG, 16'h8D00, 3, 1'b1, 0);
      run_op("rotr15",  16'h1234, 4'd15, DIR_RIGHT, MODE_ROT, 16'h2468, 6, 1'b0, 0);
      run_op("amt0",    16'hBEEF, 4'd0,  DIR_LEFT,  MODE_LOG, 16'hBEEF, 0, 1'b0, 5);
      run_op("logr4_s", 16'h0013, 4'd4,  DIR_RIGHT, MODE_LOG, 16'h0001, 1, 1'b1, 0);
      run_op("logr4_n", 16'h0010, 4'd4,  DIR_RIGHT, MODE_LOG, 16'h0001, 1, 1'b0, 0);
      run_op("logr5",   16'h8001, 4'd5,  DIR_RIGHT, MODE_LOG, 16'h0400, 2, 1'b1, 1);
      run_op("rotr7",   16'hF00F, 4'd7,  DIR_RIGHT, MODE_ROT, 16'h1FE0, 4, 1'b0, 0);

      // Abort an amt=15 operation with reset in the middle of SHIFT.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hFFFF;
      bus.in_amt   = 4'd15;
      bus.in_dir   = DIR_LEFT;
      bus.in_rot   = MODE_LOG;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("abort_pre_busy", 32'(busy), 32'd1);
      chk("abort_pre_state", 32'(dbg_state), 32'(ST_SHIFT));
      #2;
      rst = 1'b1;
      #1;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_out_data", 32'(bus.out_data), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      rst = 1'b0;
      run_op("post_rst", 16'h1234, 4'd4, DIR_LEFT, MODE_ROT, 16'h2341, 1, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule : tb_iter_shift_engine
